soc_system_pio_ext: RTL and testbench

- Parametrised successor to the simple Avalon-MM output-only PIO register.
- Adds per-bit set and clear writes, a timed auto-clearing pulse mode, and a synchronised input port.
- Input port has rising-edge capture and a maskable interrupt.
- Sits on the HPS lightweight bridge as an Avalon-MM slave with zero-wait-state reads. Drives fabric control bits and collects fabric status bits.

---
 rtl/soc_system_pio_ext.sv | 152 +++++++++++++++
 tb/tb_soc_system_pio_ext.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_ext.sv
// soc_system_pio_ext: Avalon-MM slave PIO with per-bit set/clear, timed
// auto-clearing pulse bits, a synchronised input port with rising-edge
// capture, and a maskable level interrupt.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   address[2:0]        word address
//   chipselect, write_n write occurs when chipselect=1 and write_n=0
//   writedata[31:0]     write data; bits above DATA_WIDTH ignored
//   readdata[31:0]      combinational read data, zero-extended
//   in_port             asynchronous fabric status inputs
//   out_port            output control register
//   irq                 |(edge_cap & irq_mask)
module soc_system_pio_ext #(
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
   parameter int unsigned           PULSE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  irq
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned BUS_W = 32;

   localparam logic [2:0] A_OUT_DATA = 3'd0;
   localparam logic [2:0] A_IN_DATA  = 3'd1;
   localparam logic [2:0] A_IRQ_MASK = 3'd2;
   localparam logic [2:0] A_EDGE_CAP = 3'd3;
   localparam logic [2:0] A_OUT_SET  = 3'd4;
   localparam logic [2:0] A_OUT_CLR  = 3'd5;
   localparam logic [2:0] A_PULSE    = 3'd6;

   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic [DATA_WIDTH-1:0] pulse_mask_q, pulse_mask_d;
   logic [CNT_W-1:0]      pulse_cnt_q, pulse_cnt_d;
   logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [DATA_WIDTH-1:0] edge_cap_q, edge_cap_d;
   logic [DATA_WIDTH-1:0] sync1_q, sync1_d;
   logic [DATA_WIDTH-1:0] sync2_q, sync2_d;
   logic [DATA_WIDTH-1:0] in_prev_q, in_prev_d;

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wd;
   logic [DATA_WIDTH-1:0] rise;
   logic [DATA_WIDTH-1:0] w1c;
   logic                  expire;

   assign wr_en = chipselect & ~write_n;
   assign wd    = writedata[DATA_WIDTH-1:0];

   // Two-flop synchroniser followed by the edge-detect stage
   assign sync1_d   = in_port;
   assign sync2_d   = sync1_q;
   assign in_prev_d = sync2_q;
   assign rise      = sync2_q & ~in_prev_q;

   // Pulse expiry first, then the CPU write layered on top of it
   always_comb begin
      out_d        = out_q;
      pulse_mask_d = pulse_mask_q;
      pulse_cnt_d  = pulse_cnt_q;
      irq_mask_d   = irq_mask_q;
      w1c          = '0;
      expire       = (pulse_cnt_q == CNT_W'(1));

      if (expire) begin
         out_d        = out_q & ~pulse_mask_q;
         pulse_mask_d = '0;
         pulse_cnt_d  = '0;
      end else if (pulse_cnt_q != '0) begin
         pulse_cnt_d  = pulse_cnt_q - CNT_W'(1);
      end

      if (wr_en) begin
         case (address)
            A_OUT_DATA: begin
               out_d        = wd;
               pulse_mask_d = '0;
            end
            A_IRQ_MASK: irq_mask_d = wd;
            A_EDGE_CAP: w1c = wd;
            // Set/clear make the touched bits permanent
            A_OUT_SET: begin
               out_d        = out_d | wd;
               pulse_mask_d = pulse_mask_d & ~wd;
            end
            A_OUT_CLR: begin
               out_d        = out_d & ~wd;
               pulse_mask_d = pulse_mask_d & ~wd;
            end
            // Reload wins over expiry: mask already cleared above on expiry
            A_PULSE: begin
               out_d        = out_d | wd;
               pulse_mask_d = pulse_mask_d | wd;
               pulse_cnt_d  = CNT_W'(PULSE_CYCLES);
            end
            default: ;
         endcase
      end

      // A fresh rise beats a simultaneous write-1-to-clear
      edge_cap_d = (edge_cap_q & ~w1c) | rise;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q        <= RESET_VALUE;
         pulse_mask_q <= '0;
         pulse_cnt_q  <= '0;
         irq_mask_q   <= '0;
         edge_cap_q   <= '0;
         sync1_q      <= '0;
         sync2_q      <= '0;
         in_prev_q    <= '0;
      end else begin
         out_q        <= out_d;
         pulse_mask_q <= pulse_mask_d;
         pulse_cnt_q  <= pulse_cnt_d;
         irq_mask_q   <= irq_mask_d;
         edge_cap_q   <= edge_cap_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         in_prev_q    <= in_prev_d;
      end
   end

   // Zero-latency read mux, no side effects
   always_comb begin
      readdata = '0;
      case (address)
         A_OUT_DATA: readdata = BUS_W'(out_q);
         A_IN_DATA:  readdata = BUS_W'(sync2_q);
         A_IRQ_MASK: readdata = BUS_W'(irq_mask_q);
         A_EDGE_CAP: readdata = BUS_W'(edge_cap_q);
         A_PULSE:    readdata = BUS_W'(pulse_cnt_q);
         default:    readdata = '0;
      endcase
   end

   assign out_port = out_q;
   assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_soc_system_pio_ext.sv
// tb_soc_system_pio_ext: directed test-plan steps plus a randomized phase,
// all checked against a behavioural model of the register map.
module tb_soc_system_pio_ext;

   localparam int unsigned    DW  = 32;
   localparam logic [31:0]    RV  = 32'h0000_00A5;
   localparam int unsigned    PC  = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  address = 3'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [31:0] in_port = '0;
   logic [31:0] out_port;
   logic        irq;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Behavioural model state
   logic [31:0] m_out, m_mask, m_irq_mask, m_edge, m_s1, m_s2, m_prev;
   int          m_cnt;

   soc_system_pio_ext #(
      .DATA_WIDTH  (DW),
      .RESET_VALUE (RV),
      .PULSE_CYCLES(PC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .in_port   (in_port),
      .out_port  (out_port),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_out = RV; m_mask = '0; m_irq_mask = '0; m_edge = '0;
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_cnt = 0;
   endtask

   // One rising edge of the register map, from the spec's rules
   task automatic model_step();
      logic        wr;
      logic [31:0] wd, rise, clr;
      if (reset) begin
         model_reset();
         return;
      end
      wr   = chipselect && !write_n;
      wd   = writedata;
      rise = m_s2 & ~m_prev;
      clr  = (wr && address == 3'd3) ? wd : 32'h0;
      m_edge = (m_edge & ~clr) | rise;
      m_prev = m_s2;
      m_s2   = m_s1;
      m_s1   = in_port;
      if (m_cnt == 1) begin
         m_out  = m_out & ~m_mask;
         m_mask = '0;
         m_cnt  = 0;
      end else if (m_cnt > 0) begin
         m_cnt = m_cnt - 1;
      end
      if (wr) begin
         case (address)
            3'd0: begin m_out = wd; m_mask = '0; end
            3'd2: m_irq_mask = wd;
            3'd4: begin m_out = m_out | wd;  m_mask = m_mask & ~wd; end
            3'd5: begin m_out = m_out & ~wd; m_mask = m_mask & ~wd; end
            3'd6: begin m_out = m_out | wd;  m_mask = m_mask | wd; m_cnt = PC; end
            default: ;
         endcase
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [2:0] a);
      case (a)
         3'd0:    return m_out;
         3'd1:    return m_s2;
         3'd2:    return m_irq_mask;
         3'd3:    return m_edge;
         3'd6:    return 32'(m_cnt);
         default: return 32'h0;
      endcase
   endfunction

   task automatic check_all();
      logic [2:0] a;
      check("out_port", out_port, m_out);
      check("irq", {31'b0, irq}, {31'b0, |(m_edge & m_irq_mask)});
      a = 3'(cyc);
      address = a;
      #1;
      check($sformatf("readdata[%0d]", a), readdata, exp_read(a));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_write(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      cycle();
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   initial begin
      logic [31:0] v;
      int          hi;

      // Reset state
      model_reset();
      #1 reset = 1'b1;
      #1;
      check("rst out_port", out_port, 32'hA5);
      check("rst irq", {31'b0, irq}, 32'h0);
      idle(2);
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), v);
         check($sformatf("rst read[%0d]", a), v, (a == 0) ? 32'hA5 : 32'h0);
      end
      reset = 1'b0;
      idle(3);
      check("post-rst out_port", out_port, 32'hA5);

      // Set / clear
      do_write(3'd0, 32'hF0F0);
      do_write(3'd4, 32'h000F);
      do_write(3'd5, 32'h00F0);
      check("setclr out_port", out_port, 32'hF00F);
      rd(3'd4, v); check("read OUT_SET", v, 32'h0);
      rd(3'd5, v); check("read OUT_CLR", v, 32'h0);
      do_write(3'd7, 32'hFFFF);
      check("reserved write", out_port, 32'hF00F);

      // Single pulse: bit0 high for exactly PC cycles
      do_write(3'd0, 32'h0);
      do_write(3'd6, 32'h1);
      hi = out_port[0] ? 1 : 0;
      for (int i = 0; i < 24; i++) begin
         idle(1);
         if (i == 4) begin
            rd(3'd6, v);
            check("pulse count mid", v, 32'd11);
         end
         if (out_port[0]) hi++;
      end
      check("pulse width", 32'(hi), 32'(PC));
      check("pulse done", out_port, 32'h0);

      // Retrigger at cycle 10
      do_write(3'd6, 32'h1);
      idle(9);
      do_write(3'd6, 32'h2);
      idle(15);
      check("retrig still high", out_port, 32'h3);
      idle(1);
      check("retrig fall", out_port, 32'h0);

      // Cancel bit0's auto-clear with OUT_SET
      do_write(3'd6, 32'h3);
      idle(4);
      do_write(3'd4, 32'h1);
      idle(10);
      check("cancel pre-expiry", out_port, 32'h3);
      idle(1);
      check("cancel expiry", out_port, 32'h1);
      rd(3'd6, v); check("cancel cnt zero", v, 32'h0);

      // Edge capture and interrupt
      do_write(3'd0, 32'h0);
      do_write(3'd2, 32'h4);
      in_port = 32'h4;
      idle(2);
      rd(3'd3, v); check("edge latency early", v, 32'h0);
      idle(1);
      rd(3'd3, v); check("edge bit2", v, 32'h4);
      check("irq bit2", {31'b0, irq}, 32'h1);
      in_port = 32'h5;
      idle(3);
      rd(3'd3, v); check("edge bit0", v, 32'h5);
      check("irq still", {31'b0, irq}, 32'h1);
      do_write(3'd3, 32'h4);
      check("irq cleared", {31'b0, irq}, 32'h0);
      rd(3'd3, v); check("edge after w1c", v, 32'h1);

      // W1C colliding with a new rise on bit2
      in_port = 32'h1;
      idle(4);
      in_port = 32'h5;
      idle(2);
      do_write(3'd3, 32'h4);
      rd(3'd3, v); check("collision edge", v & 32'h4, 32'h4);
      check("collision irq", {31'b0, irq}, 32'h1);

      // Asynchronous reset mid-pulse
      do_write(3'd6, 32'h10);
      idle(3);
      reset = 1'b1;
      model_reset();
      #1;
      check("async rst out", out_port, 32'hA5);
      check("async rst irq", {31'b0, irq}, 32'h0);
      rd(3'd6, v); check("async rst cnt", v, 32'h0);
      cycle();
      reset = 1'b0;
      idle(2);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         int r;
         if ($urandom_range(0, 7) == 0) in_port = $urandom;
         r = int'($urandom_range(0, 7));
         address   = 3'($urandom_range(0, 7));
         writedata = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         if (r < 2) begin
            chipselect = 1'b1; write_n = 1'b0;
         end else if (r == 2) begin
            chipselect = 1'b0; write_n = 1'b0;
         end
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
